dpi_timing_meter: RTL

Measures the incoming DPI pixel clock frequency (in kHz) and the active line width (in pixels). The measurement runs entirely in the system clock domain by oversampling DPI_PCLK and DPI_DE. It sits directly upstream of the DPI sync detector and drives that detector's FREQ and WIDTH inputs. Both results are registered and held stable between updates.

---
 rtl/dpi_timing_meter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dpi_timing_meter.sv
// dpi_timing_meter
//   Measures the DPI pixel clock frequency (kHz) and the active line width
//   (pixels), working purely in the system clock domain by oversampling
//   DPI_PCLK and DPI_DE. Results are registered and held between updates.
//
// Parameters
//   CLK_FREQ_KHZ : CLK frequency in kHz; also the gate window length in CLK
//                  cycles (1 ms window, so edges per window == kHz)
//   GATE_W       : gate counter width, 2**GATE_W >= CLK_FREQ_KHZ
//
// Ports
//   CLK          in   system clock (>= 3x pixel clock)
//   RESET        in   synchronous, active-high reset
//   DPI_PCLK     in   pixel clock, treated as asynchronous data
//   DPI_DE       in   data enable, asynchronous, sampled on PCLK rises
//   FREQ         out  [15:0] pixel clock frequency in kHz, saturating
//   WIDTH        out  [10:0] pixels in the last completed line, saturating
//   FREQ_VALID   out  one-cycle pulse when FREQ is written
//   WIDTH_VALID  out  one-cycle pulse when WIDTH is written
module dpi_timing_meter #(
  parameter int CLK_FREQ_KHZ = 100000,
  parameter int GATE_W       = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DPI_PCLK,
  input  logic        DPI_DE,
  output logic [15:0] FREQ,
  output logic [10:0] WIDTH,
  output logic        FREQ_VALID,
  output logic        WIDTH_VALID
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_FREQ_KHZ - 1);
  localparam logic [15:0]       EDGE_MAX  = 16'hFFFF;
  localparam logic [10:0]       PIX_MAX   = 11'h7FF;

  // Input conditioning: 2-FF synchronizers, plus one extra PCLK stage for
  // edge detection. de_s lines up with pclk_s, so at a detected rise de_s
  // holds DE as it was around that PCLK edge.
  logic pclk_meta, pclk_s, pclk_d;
  logic de_meta, de_s;

  logic [GATE_W-1:0] gate;
  logic [15:0]       edge_cnt;
  logic [10:0]       pix_cnt;
  logic              de_prev;
  logic              line_seen;

  logic pclk_rise;
  logic terminal;
  logic line_end;

  assign pclk_rise = pclk_s & ~pclk_d;
  assign terminal  = (gate == GATE_LAST);
  assign line_end  = pclk_rise & ~de_s & de_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pclk_meta   <= 1'b0;
      pclk_s      <= 1'b0;
      pclk_d      <= 1'b0;
      de_meta     <= 1'b0;
      de_s        <= 1'b0;
      gate        <= '0;
      edge_cnt    <= '0;
      pix_cnt     <= '0;
      de_prev     <= 1'b0;
      line_seen   <= 1'b0;
      FREQ        <= '0;
      WIDTH       <= '0;
      FREQ_VALID  <= 1'b0;
      WIDTH_VALID <= 1'b0;
    end else begin
      pclk_meta   <= DPI_PCLK;
      pclk_s      <= pclk_meta;
      pclk_d      <= pclk_s;
      de_meta     <= DPI_DE;
      de_s        <= de_meta;
      FREQ_VALID  <= 1'b0;
      WIDTH_VALID <= 1'b0;

      // Gate window and edge counter. A rise on the terminal cycle is folded
      // into the closing result and the counter restarts from zero, so the
      // edge belongs to exactly one window.
      if (terminal) begin
        gate       <= '0;
        FREQ       <= (edge_cnt == EDGE_MAX) ? EDGE_MAX
                                             : edge_cnt + {15'd0, pclk_rise};
        edge_cnt   <= '0;
        FREQ_VALID <= 1'b1;
      end else begin
        gate <= gate + 1'b1;
        if (pclk_rise && edge_cnt != EDGE_MAX)
          edge_cnt <= edge_cnt + 1'b1;
      end

      // Line width: count DE-high pixels, report on the first low pixel.
      if (pclk_rise) begin
        if (de_s) begin
          if (pix_cnt != PIX_MAX)
            pix_cnt <= pix_cnt + 1'b1;
          de_prev <= 1'b1;
        end else if (de_prev) begin
          WIDTH       <= pix_cnt;
          pix_cnt     <= '0;
          de_prev     <= 1'b0;
          WIDTH_VALID <= 1'b1;
        end
      end

      // No completed line in a whole window: force WIDTH to 0 so downstream
      // sync drops. A line finishing on this very cycle takes priority.
      if (terminal && !line_seen && !line_end) begin
        WIDTH       <= '0;
        WIDTH_VALID <= 1'b1;
      end

      if (terminal)
        line_seen <= 1'b0;
      else if (line_end)
        line_seen <= 1'b1;
    end
  end

endmodule
